// File: rtl/bfs_mem_pkg.sv
// Shared memory-side definitions for the BFS accelerator: AXI constants,
// the node fetcher state encoding and an arsize helper.
package bfs_mem_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } fetch_state_t;

    function automatic logic [2:0] arsize_of(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/burst_node_fetcher_splitter.sv
// Combinational burst sizing: picks the largest INCR burst that fits the
// remaining node count, the maximum burst length and the next 4 KB boundary.
module burst_splitter
    import bfs_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16,
    parameter int MAX_BURST   = 16
) (
    input  logic [11:0]            addr_low,
    input  logic [COUNT_WIDTH-1:0] remaining,
    output logic [8:0]             len,
    output logic [7:0]             arlen
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);

    logic [12:0] to_boundary;
    logic [12:0] boundary_beats;
    logic [31:0] rem_ext;
    logic [8:0]  cap;

    always_comb begin
        to_boundary    = 13'(BOUNDARY_4K) - {1'b0, addr_low};
        boundary_beats = to_boundary >> SHIFT;
        rem_ext        = 32'(remaining);
        cap            = 9'(MAX_BURST);
        if (boundary_beats < 13'(cap)) begin
            cap = boundary_beats[8:0];
        end
        if (rem_ext < 32'(cap)) begin
            cap = rem_ext[8:0];
        end
        len   = cap;
        // cap is never zero while a burst is being requested
        arlen = 8'(cap - 9'd1);
    end

endmodule

// File: rtl/burst_node_fetcher.sv
// Successor node fetcher: splits a node-list request into AXI4 INCR bursts and
// streams the returned words. Define NODE_FETCH_ERR_ABORT_EN to stop after an error.
module burst_node_fetcher
    import bfs_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_BURST   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rvalid,
    input  logic                   m_axi_rlast,
    output logic                   m_axi_rready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [COUNT_WIDTH-1:0] req_count,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [DATA_WIDTH-1:0]  node_data,
    output logic                   node_valid,
    input  logic                   node_ready,
    output logic                   node_last,
    output logic                   fetch_done,
    output logic                   fetch_err,
    output logic                   busy
);

    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [8:0]             beats;
    logic [8:0]             len_q;
    logic                   err;

    logic [8:0]             split_len;
    logic [7:0]             split_arlen;
    logic                   r_hs;
    logic                   last_beat;
    logic                   final_node;
    logic                   beat_err;
    logic                   abort;

    burst_splitter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_BURST   (MAX_BURST)
    ) u_splitter (
        .addr_low  (addr[11:0]),
        .remaining (remaining),
        .len       (split_len),
        .arlen     (split_arlen)
    );

    assign r_hs       = (state == ST_DATA) && m_axi_rvalid && node_ready;
    assign last_beat  = (beats == 9'd1);
    assign final_node = (remaining == COUNT_WIDTH'(1));
    // A stray or missing rlast is a protocol error; the beat count still rules.
    assign beat_err   = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat);

`ifdef NODE_FETCH_ERR_ABORT_EN
    assign abort = err || beat_err;
`else
    assign abort = 1'b0;
`endif

    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = (state == ST_ADDR) ? split_arlen : 8'd0;
    assign m_axi_arsize  = arsize_of(DATA_WIDTH);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign node_data     = m_axi_rdata;
    assign fetch_err     = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        node_valid    = 1'b0;
        node_last     = 1'b0;
        fetch_done    = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (req_count == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready = node_ready;
                node_valid   = m_axi_rvalid;
                node_last    = m_axi_rvalid && final_node;
                if (r_hs && last_beat) begin
                    state_next = (final_node || abort) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: begin
                fetch_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            beats     <= '0;
            len_q     <= '0;
            err       <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                addr      <= req_addr & ~LOW_MASK;
                remaining <= req_count;
                err       <= 1'b0;
            end
            if (state == ST_ADDR && m_axi_arready) begin
                beats <= split_len;
                len_q <= split_len;
            end
            if (r_hs) begin
                beats     <= beats - 9'd1;
                remaining <= remaining - COUNT_WIDTH'(1);
                if (beat_err) begin
                    err <= 1'b1;
                end
                if (last_beat) begin
                    addr <= addr + (ADDR_WIDTH'(len_q) << SHIFT);
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_node_fetcher.sv
// Directed bench for burst_node_fetcher with a small AXI read slave whose data
// word is the byte address of the beat.
module tb_burst_node_fetcher;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int MB = 16;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rready;
    logic [AW-1:0] req_addr = '0;
    logic [CW-1:0] req_count = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] node_data;
    logic          node_valid;
    logic          node_ready = 1'b0;
    logic          node_last;
    logic          fetch_done;
    logic          fetch_err;
    logic          busy;

    burst_node_fetcher #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MAX_BURST   (MB),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rready  (m_axi_rready),
        .req_addr      (req_addr),
        .req_count     (req_count),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .node_data     (node_data),
        .node_valid    (node_valid),
        .node_ready    (node_ready),
        .node_last     (node_last),
        .fetch_done    (fetch_done),
        .fetch_err     (fetch_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave/monitor state, written only by the monitor process.
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [63:0] node_q[$];
    logic        last_q[$];
    logic [31:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    int beat = 0, served = 0, cyc = 0;
    int done_cnt = 0, done_cyc = -1, acc_cyc = -1, last_hs_cyc = -1;
    int first_arv_cyc = -1, rr_cyc = -1, nv_cnt = 0, rviol = 0, stab_viol = 0;
    bit rr_armed = 0, prev_pend = 0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    // Stimulus knobs, written only by the main process.
    int err_ar = -1, err_beat = -1;
    bit rand_ready = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            m_axi_arready = (cyc % 3 != 0);
            node_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bq_addr.size() > 0) begin
                m_axi_rvalid = (cyc % 5 != 4);
                m_axi_rdata  = {32'h0, bq_addr[0] + 32'(beat * 8)};
                m_axi_rlast  = (beat == int'(bq_len[0]));
                m_axi_rresp  = (served == err_ar && beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
            #1;
            if (!rst_n) begin
                bq_addr.delete();
                bq_len.delete();
                beat = 0;
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                first_arv_cyc = -1;
                served = 0;
            end
            if (m_axi_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
            if (prev_pend && m_axi_arvalid &&
                (m_axi_araddr != prev_addr || m_axi_arlen != prev_len)) stab_viol++;
            prev_pend = m_axi_arvalid && !m_axi_arready;
            prev_addr = m_axi_araddr;
            prev_len  = m_axi_arlen;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
                bq_addr.push_back(m_axi_araddr);
                bq_len.push_back(m_axi_arlen);
            end
            if (node_valid && node_ready) begin
                node_q.push_back(node_data);
                last_q.push_back(node_last);
            end
            if (m_axi_rvalid && m_axi_rready && bq_addr.size() > 0) begin
                last_hs_cyc = cyc;
                if (beat == int'(bq_len[0])) begin
                    void'(bq_addr.pop_front());
                    void'(bq_len.pop_front());
                    beat = 0;
                    served++;
                end else begin
                    beat++;
                end
            end
            if (node_valid) nv_cnt++;
            if (m_axi_rready && !node_ready) rviol++;
            if (rr_armed && req_ready) begin
                rr_cyc = cyc;
                rr_armed = 0;
            end
            if (fetch_done) begin
                done_cnt++;
                done_cyc = cyc;
                rr_armed = 1;
            end
        end
    end

    int ar0, nd0, done0, nv0, rv0, sv0;

    task automatic run_req(input logic [31:0] a, input logic [15:0] n);
        ar0 = ar_addr_q.size();
        nd0 = node_q.size();
        done0 = done_cnt;
        nv0 = nv_cnt;
        rv0 = rviol;
        sv0 = stab_viol;
        @(negedge clk);
        req_addr  = a;
        req_count = n;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == done0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
        if (ar0 + idx < ar_addr_q.size()) begin
            chk({tag, "_araddr"}, ar_addr_q[ar0 + idx], a);
            chk({tag, "_arlen"}, ar_len_q[ar0 + idx], l);
        end else begin
            chk({tag, "_ar_missing"}, ar_addr_q.size(), ar0 + idx + 1);
        end
    endtask

    task automatic check_nodes(input string tag, input logic [31:0] base, input int n, input int last_idx);
        int lasts = 0;
        chk({tag, "_nodes"}, node_q.size() - nd0, n);
        for (int i = 0; i < n && nd0 + i < node_q.size(); i++) begin
            chk({tag, "_data"}, node_q[nd0 + i], {32'h0, base + 32'(i * 8)});
            if (last_q[nd0 + i]) lasts++;
        end
        chk({tag, "_last_count"}, lasts, (last_idx >= 0) ? 1 : 0);
        if (last_idx >= 0 && nd0 + last_idx < node_q.size())
            chk({tag, "_last_pos"}, last_q[nd0 + last_idx], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_node_valid", node_valid, 0);
        chk("rst_node_last", node_last, 0);
        chk("rst_fetch_done", fetch_done, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("arsize", m_axi_arsize, 3);
        chk("arburst", m_axi_arburst, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single burst
        run_req(32'h1000, 4);
        chk("t1_done", done_cnt - done0, 1);
        chk("t1_ar_count", ar_addr_q.size() - ar0, 1);
        check_ar("t1", 0, 32'h1000, 8'd3);
        check_nodes("t1", 32'h1000, 4, 3);
        chk("t1_err", fetch_err, 0);
        chk("t1_done_timing", done_cyc, last_hs_cyc + 1);
        chk("t1_first_arvalid", first_arv_cyc, acc_cyc + 1);
        chk("t1_req_ready_back", rr_cyc, done_cyc + 1);
        chk("t1_idle", busy, 0);

        // split by MAX_BURST
        run_req(32'h0, 40);
        chk("t2_done", done_cnt - done0, 1);
        chk("t2_ar_count", ar_addr_q.size() - ar0, 3);
        check_ar("t2_b0", 0, 32'h000, 8'd15);
        check_ar("t2_b1", 1, 32'h080, 8'd15);
        check_ar("t2_b2", 2, 32'h100, 8'd7);
        check_nodes("t2", 32'h0, 40, 39);
        chk("t2_ar_stable", stab_viol - sv0, 0);
        chk("t2_err", fetch_err, 0);

        // 4 KB boundary split
        run_req(32'h0FE0, 8);
        chk("t3_ar_count", ar_addr_q.size() - ar0, 2);
        check_ar("t3_b0", 0, 32'h0FE0, 8'd3);
        check_ar("t3_b1", 1, 32'h1000, 8'd3);
        check_nodes("t3", 32'h0FE0, 8, 7);

        // consumer backpressure
        rand_ready = 1;
        run_req(32'h2000, 16);
        rand_ready = 0;
        chk("t4_ar_count", ar_addr_q.size() - ar0, 1);
        check_ar("t4", 0, 32'h2000, 8'd15);
        check_nodes("t4", 32'h2000, 16, 15);
        chk("t4_rready_mirror", rviol - rv0, 0);

        // zero-length request
        run_req(32'h3000, 0);
        chk("t5_done", done_cnt - done0, 1);
        chk("t5_ar_count", ar_addr_q.size() - ar0, 0);
        chk("t5_node_valid", nv_cnt - nv0, 0);
        chk("t5_done_timing", done_cyc, acc_cyc + 1);

        // SLVERR on beat 3 of the second burst
        err_ar = 1;
        err_beat = 3;
        run_req(32'h0, 40);
        err_ar = -1;
        err_beat = -1;
        chk("t6_done", done_cnt - done0, 1);
        chk("t6_err", fetch_err, 1);
`ifdef NODE_FETCH_ERR_ABORT_EN
        chk("t6_ar_count", ar_addr_q.size() - ar0, 2);
        check_nodes("t6", 32'h0, 32, -1);
`else
        chk("t6_ar_count", ar_addr_q.size() - ar0, 3);
        check_ar("t6_b2", 2, 32'h100, 8'd7);
        check_nodes("t6", 32'h0, 40, 39);
`endif

        // unaligned start, error cleared on accept
        run_req(32'h3005, 2);
        chk("t7_ar_count", ar_addr_q.size() - ar0, 1);
        check_ar("t7", 0, 32'h3000, 8'd1);
        check_nodes("t7", 32'h3000, 2, 1);
        chk("t7_err_cleared", fetch_err, 0);

        // asynchronous reset in the middle of a fetch
        @(negedge clk);
        req_addr  = 32'h0;
        req_count = 16'd40;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_busy", busy, 0);
        chk("t8_arvalid", m_axi_arvalid, 0);
        chk("t8_node_valid", node_valid, 0);
        chk("t8_req_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_req(32'h1000, 4);
        chk("t8_ar_count", ar_addr_q.size() - ar0, 1);
        check_ar("t8", 0, 32'h1000, 8'd3);
        check_nodes("t8", 32'h1000, 4, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
